unidade_escrita_reg: RTL and testbench

- Write-side controller that drives the register bank write port: `end_escrita`, `dados_escrita`, `EscreveReg`.
- On reset release it runs an initialisation sequence: r0=0, r1=VALOR_R1.
- After initialisation it merges single-cycle ALU writebacks with buffered memory-load writebacks.
- Sits between the execute/memory stages and the register bank; it is the only writer of the bank.

---
 rtl/unidade_escrita_reg_pkg.sv | 18 +
 rtl/unidade_escrita_reg_fila_escrita.sv | 97 +++++++++
 rtl/unidade_escrita_reg.sv | 140 ++++++++++++++
 tb/tb_unidade_escrita_reg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_escrita_reg_pkg.sv
// Shared constants and state encoding for the register-bank write controller.
package pacote_processador;

    localparam int LARG_END  = 6;
    localparam int LARG_DADO = 32;
    localparam int PROF_FILA = 4;
    localparam int VALOR_R1  = 13249;

    localparam logic [LARG_END-1:0] REG_ZERO       = 6'd0;
    localparam logic [LARG_END-1:0] REG_LIMITE_RAM = 6'd1;

    typedef enum logic [1:0] {
        INIT_R0 = 2'd0,
        INIT_R1 = 2'd1,
        RUN     = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_escrita_reg_fila_escrita.sv
// Load-writeback FIFO; entries can be cancelled in place by a newer ALU write
// to the same register and are then popped without producing a write.
module fila_escrita #(
    parameter int LARG_END  = pacote_processador::LARG_END,
    parameter int LARG_DADO = pacote_processador::LARG_DADO,
    parameter int PROF      = pacote_processador::PROF_FILA
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [LARG_END-1:0]  ent_end,
    input  logic [LARG_DADO-1:0] ent_dado,
    input  logic                 pop,
    input  logic                 inval,
    input  logic [LARG_END-1:0]  inval_end,
    output logic                 cheia,
    output logic                 vazia,
    output logic                 cab_valido,
    output logic [LARG_END-1:0]  cab_end,
    output logic [LARG_DADO-1:0] cab_dado
);

    localparam int LARG_PTR = $clog2(PROF);

    logic [LARG_PTR-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [LARG_PTR:0]    cnt_q, cnt_d;
    logic [PROF-1:0]      val_q, val_d;
    logic [LARG_END-1:0]  end_q  [PROF];
    logic [LARG_END-1:0]  end_d  [PROF];
    logic [LARG_DADO-1:0] dado_q [PROF];
    logic [LARG_DADO-1:0] dado_d [PROF];
    logic                 do_push_s, do_pop_s;

    assign vazia      = (cnt_q == (LARG_PTR+1)'(0));
    assign cheia      = (cnt_q == (LARG_PTR+1)'(PROF));
    assign do_pop_s   = pop && !vazia;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push_s  = push && (!cheia || do_pop_s);
    assign cab_valido = val_q[rd_q] && !vazia;
    assign cab_end    = end_q[rd_q];
    assign cab_dado   = dado_q[rd_q];

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        end_d  = end_q;
        dado_d = dado_q;
        val_d  = val_q;
        for (int i = 0; i < PROF; i++) begin
            if (inval && val_q[i] && (end_q[i] == inval_end)) begin
                val_d[i] = 1'b0;
            end else begin
                val_d[i] = val_q[i];
            end
        end
        if (do_pop_s) begin
            val_d[rd_q] = 1'b0;
            rd_d        = rd_q + LARG_PTR'(1);
        end else begin
            rd_d = rd_q;
        end
        if (do_push_s) begin
            val_d[wr_q]  = 1'b1;
            end_d[wr_q]  = ent_end;
            dado_d[wr_q] = ent_dado;
            wr_d         = wr_q + LARG_PTR'(1);
        end else begin
            wr_d = wr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + (LARG_PTR+1)'(1);
            2'b01:   cnt_d = cnt_q - (LARG_PTR+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            val_q <= '0;
            for (int i = 0; i < PROF; i++) begin
                end_q[i]  <= '0;
                dado_q[i] <= '0;
            end
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            val_q  <= val_d;
            end_q  <= end_d;
            dado_q <= dado_d;
        end
    end

endmodule

// File: rtl/unidade_escrita_reg.sv
// Sole writer of the register bank: initialises r0/r1, then merges ALU
// writebacks (priority) with queued memory-load writebacks.
module unidade_escrita_reg #(
    parameter int LARG_END  = pacote_processador::LARG_END,
    parameter int LARG_DADO = pacote_processador::LARG_DADO,
    parameter int PROF_FILA = pacote_processador::PROF_FILA,
    parameter int VALOR_R1  = pacote_processador::VALOR_R1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ula_valida,
    input  logic [LARG_END-1:0]  ula_end,
    input  logic [LARG_DADO-1:0] ula_dado,
    input  logic                 mem_valida,
    input  logic [LARG_END-1:0]  mem_end,
    input  logic [LARG_DADO-1:0] mem_dado,
    output logic                 mem_pronto,
    output logic [LARG_END-1:0]  end_escrita,
    output logic [LARG_DADO-1:0] dados_escrita,
    output logic                 EscreveReg,
    output logic                 init_ativo,
    output logic                 erro_estouro
);

    import pacote_processador::*;

    estado_t              estado_q, estado_d;
    logic [LARG_END-1:0]  end_q, end_d;
    logic [LARG_DADO-1:0] dado_q, dado_d;
    logic                 we_q, we_d;
    logic                 init_q, init_d;
    logic                 erro_q, erro_d;

    logic                 em_run_s, ula_ok_s, mem_ok_s, pop_s, estouro_s;
    logic                 cheia_s, vazia_s, cab_valido_s;
    logic [LARG_END-1:0]  cab_end_s;
    logic [LARG_DADO-1:0] cab_dado_s;

    assign em_run_s  = (estado_q == RUN);
    assign ula_ok_s  = em_run_s && ula_valida && (ula_end != LARG_END'(REG_ZERO));
    // A load racing an ALU write to the same register is stale; drop it quietly.
    assign mem_ok_s  = em_run_s && mem_valida && (mem_end != LARG_END'(REG_ZERO))
                       && !(ula_ok_s && (ula_end == mem_end));
    assign pop_s     = em_run_s && !ula_ok_s && !vazia_s;
    assign estouro_s = mem_ok_s && cheia_s && !pop_s;
    assign mem_pronto = em_run_s && !cheia_s;

    fila_escrita #(
        .LARG_END  (LARG_END),
        .LARG_DADO (LARG_DADO),
        .PROF      (PROF_FILA)
    ) u_fila (
        .clock      (clock),
        .reset      (reset),
        .push       (mem_ok_s),
        .ent_end    (mem_end),
        .ent_dado   (mem_dado),
        .pop        (pop_s),
        .inval      (ula_ok_s),
        .inval_end  (ula_end),
        .cheia      (cheia_s),
        .vazia      (vazia_s),
        .cab_valido (cab_valido_s),
        .cab_end    (cab_end_s),
        .cab_dado   (cab_dado_s)
    );

    // Sequencer: init writes, then ALU-over-FIFO arbitration of the bank port.
    always_comb begin
        estado_d = estado_q;
        end_d    = end_q;
        dado_d   = dado_q;
        we_d     = 1'b0;
        init_d   = init_q;
        erro_d   = erro_q;
        case (estado_q)
            INIT_R0: begin
                end_d    = LARG_END'(REG_ZERO);
                dado_d   = LARG_DADO'(0);
                we_d     = 1'b1;
                estado_d = INIT_R1;
            end
            INIT_R1: begin
                end_d    = LARG_END'(REG_LIMITE_RAM);
                dado_d   = LARG_DADO'(VALOR_R1);
                we_d     = 1'b1;
                init_d   = 1'b0;
                estado_d = RUN;
            end
            RUN: begin
                if (ula_ok_s) begin
                    end_d  = ula_end;
                    dado_d = ula_dado;
                    we_d   = 1'b1;
                end else if (pop_s && cab_valido_s) begin
                    end_d  = cab_end_s;
                    dado_d = cab_dado_s;
                    we_d   = 1'b1;
                end else begin
                    we_d = 1'b0;
                end
                if (estouro_s) begin
                    erro_d = 1'b1;
                end else begin
                    erro_d = erro_q;
                end
            end
            default: begin
                estado_d = INIT_R0;
                init_d   = 1'b1;
            end
        endcase
    end

    // Registered bank-port outputs and controller state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INIT_R0;
            end_q    <= '0;
            dado_q   <= '0;
            we_q     <= 1'b0;
            init_q   <= 1'b1;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            end_q    <= end_d;
            dado_q   <= dado_d;
            we_q     <= we_d;
            init_q   <= init_d;
            erro_q   <= erro_d;
        end
    end

    assign end_escrita   = end_q;
    assign dados_escrita = dado_q;
    assign EscreveReg    = we_q;
    assign init_ativo    = init_q;
    assign erro_estouro  = erro_q;

endmodule

// File: tb/tb_unidade_escrita_reg.sv
// Directed bench for unidade_escrita_reg: vector table plus hand sequences.
module tb_unidade_escrita_reg;

    logic        clock;
    logic        reset;
    logic        ula_valida;
    logic [5:0]  ula_end;
    logic [31:0] ula_dado;
    logic        mem_valida;
    logic [5:0]  mem_end;
    logic [31:0] mem_dado;
    logic        mem_pronto;
    logic [5:0]  end_escrita;
    logic [31:0] dados_escrita;
    logic        EscreveReg;
    logic        init_ativo;
    logic        erro_estouro;

    int passados = 0;
    int total    = 0;

    typedef struct {
        logic        uv;
        logic [5:0]  ue;
        logic [31:0] ud;
        logic        mv;
        logic [5:0]  me;
        logic [31:0] md;
        logic        we;
        logic [5:0]  ea;
        logic [31:0] ed;
        logic        pronto;
        logic        erro;
    } vet_t;

    vet_t tab[18];

    unidade_escrita_reg dut (
        .clock         (clock),
        .reset         (reset),
        .ula_valida    (ula_valida),
        .ula_end       (ula_end),
        .ula_dado      (ula_dado),
        .mem_valida    (mem_valida),
        .mem_end       (mem_end),
        .mem_dado      (mem_dado),
        .mem_pronto    (mem_pronto),
        .end_escrita   (end_escrita),
        .dados_escrita (dados_escrita),
        .EscreveReg    (EscreveReg),
        .init_ativo    (init_ativo),
        .erro_estouro  (erro_estouro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic uv, input logic [5:0] ue, input logic [31:0] ud,
                         input logic mv, input logic [5:0] me, input logic [31:0] md);
        ula_valida = uv; ula_end = ue; ula_dado = ud;
        mem_valida = mv; mem_end = me; mem_dado = md;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
        end else begin
            passados++;
        end
    endtask

    task automatic chk_porta(input string nome, input logic we, input logic [5:0] ea,
                             input logic [31:0] ed);
        chk({nome, ".we"}, {31'd0, EscreveReg}, {31'd0, we});
        if (we) begin
            chk({nome, ".end"}, {26'd0, end_escrita}, {26'd0, ea});
            chk({nome, ".dado"}, dados_escrita, ed);
        end else begin
            chk({nome, ".end_hold"}, {26'd0, end_escrita}, {26'd0, ea});
        end
    endtask

    task automatic seq_init(input string nome);
        tick();
        chk_porta({nome, ".r0"}, 1'b1, 6'd0, 32'd0);
        chk({nome, ".init_c1"}, {31'd0, init_ativo}, 32'd1);
        chk({nome, ".pronto_c1"}, {31'd0, mem_pronto}, 32'd0);
        tick();
        chk_porta({nome, ".r1"}, 1'b1, 6'd1, 32'd13249);
        chk({nome, ".init_c2"}, {31'd0, init_ativo}, 32'd0);
        tick();
        chk({nome, ".we_c3"}, {31'd0, EscreveReg}, 32'd0);
        chk({nome, ".init_c3"}, {31'd0, init_ativo}, 32'd0);
        chk({nome, ".pronto_c3"}, {31'd0, mem_pronto}, 32'd1);
    endtask

    initial begin
        tab[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 1'b0, 6'd0, 32'h0,  1'b1, 6'd5,  32'hDEADBEEF, 1'b1, 1'b0};
        tab[1]  = '{1'b1, 6'd0,  32'h12345678, 1'b0, 6'd0, 32'h0,  1'b0, 6'd5,  32'hDEADBEEF, 1'b1, 1'b0};
        tab[2]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b0, 6'd5,  32'hDEADBEEF, 1'b1, 1'b0};
        tab[3]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd7, 32'h11, 1'b0, 6'd5,  32'hDEADBEEF, 1'b1, 1'b0};
        tab[4]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b1, 6'd7,  32'h11,       1'b1, 1'b0};
        tab[5]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b0, 6'd7,  32'h11,       1'b1, 1'b0};
        tab[6]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd0, 32'h22, 1'b0, 6'd7,  32'h11,       1'b1, 1'b0};
        tab[7]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b0, 6'd7,  32'h11,       1'b1, 1'b0};
        tab[8]  = '{1'b1, 6'd3,  32'h33,       1'b1, 6'd4, 32'h44, 1'b1, 6'd3,  32'h33,       1'b1, 1'b0};
        tab[9]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b1, 6'd4,  32'h44,       1'b1, 1'b0};
        tab[10] = '{1'b1, 6'd8,  32'h55,       1'b1, 6'd8, 32'h66, 1'b1, 6'd8,  32'h55,       1'b1, 1'b0};
        tab[11] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b0, 6'd8,  32'h55,       1'b1, 1'b0};
        tab[12] = '{1'b1, 6'd10, 32'hA0,       1'b1, 6'd7, 32'h77, 1'b1, 6'd10, 32'hA0,       1'b1, 1'b0};
        tab[13] = '{1'b1, 6'd11, 32'hA1,       1'b0, 6'd0, 32'h0,  1'b1, 6'd11, 32'hA1,       1'b1, 1'b0};
        tab[14] = '{1'b1, 6'd12, 32'hA2,       1'b0, 6'd0, 32'h0,  1'b1, 6'd12, 32'hA2,       1'b1, 1'b0};
        tab[15] = '{1'b1, 6'd13, 32'hA3,       1'b0, 6'd0, 32'h0,  1'b1, 6'd13, 32'hA3,       1'b1, 1'b0};
        tab[16] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b1, 6'd7,  32'h77,       1'b1, 1'b0};
        tab[17] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  1'b0, 6'd7,  32'h77,       1'b1, 1'b0};

        // Reset state
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst.we", {31'd0, EscreveReg}, 32'd0);
        chk("rst.end", {26'd0, end_escrita}, 32'd0);
        chk("rst.dado", dados_escrita, 32'd0);
        chk("rst.init", {31'd0, init_ativo}, 32'd1);
        chk("rst.erro", {31'd0, erro_estouro}, 32'd0);
        chk("rst.pronto", {31'd0, mem_pronto}, 32'd0);
        reset = 1'b0;
        seq_init("init");

        // Table of single-cycle vectors in RUN
        for (int i = 0; i < 18; i++) begin
            drive(tab[i].uv, tab[i].ue, tab[i].ud, tab[i].mv, tab[i].me, tab[i].md);
            tick();
            chk_porta($sformatf("vet%0d", i), tab[i].we, tab[i].ea, tab[i].ed);
            chk($sformatf("vet%0d.pronto", i), {31'd0, mem_pronto}, {31'd0, tab[i].pronto});
            chk($sformatf("vet%0d.erro", i), {31'd0, erro_estouro}, {31'd0, tab[i].erro});
        end

        // Queued load superseded by a later ALU write to the same register
        drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd9, 32'hAA);
        tick();
        chk("inv.q", {31'd0, EscreveReg}, 32'd0);
        drive(1'b1, 6'd9, 32'hBB, 1'b0, 6'd0, 32'h0);
        tick();
        chk_porta("inv.ula", 1'b1, 6'd9, 32'hBB);
        idle();
        tick();
        chk_porta("inv.pop", 1'b0, 6'd9, 32'hBB);
        chk("inv.pop.dado", dados_escrita, 32'hBB);
        tick();
        chk_porta("inv.vazia", 1'b0, 6'd9, 32'hBB);

        // Overflow: ALU saturates the port while 5 loads arrive
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 6'(20 + i), 32'h200 + 32'(i), 1'b1, 6'(30 + i), 32'h100 + 32'(i));
            tick();
            chk_porta($sformatf("ovf.ula%0d", i), 1'b1, 6'(20 + i), 32'h200 + 32'(i));
            chk($sformatf("ovf.pronto%0d", i), {31'd0, mem_pronto}, (i >= 3) ? 32'd0 : 32'd1);
            chk($sformatf("ovf.erro%0d", i), {31'd0, erro_estouro}, (i == 4) ? 32'd1 : 32'd0);
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_porta($sformatf("ovf.dren%0d", i), 1'b1, 6'(30 + i), 32'h100 + 32'(i));
        end
        tick();
        chk("ovf.fim.we", {31'd0, EscreveReg}, 32'd0);
        chk("ovf.sticky", {31'd0, erro_estouro}, 32'd1);

        // Reset asserted while the FIFO holds 3 entries
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(40 + i), 32'h300, 1'b1, 6'(44 + i), 32'h400);
            tick();
        end
        idle();
        #1;
        reset = 1'b1;
        #1;
        chk("rmid.we", {31'd0, EscreveReg}, 32'd0);
        chk("rmid.end", {26'd0, end_escrita}, 32'd0);
        chk("rmid.dado", dados_escrita, 32'd0);
        chk("rmid.init", {31'd0, init_ativo}, 32'd1);
        chk("rmid.erro", {31'd0, erro_estouro}, 32'd0);
        tick();
        reset = 1'b0;
        seq_init("rmid");
        tick();
        chk("rmid.sem_fila", {31'd0, EscreveReg}, 32'd0);

        // Simultaneous push and pop on a full FIFO
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'(20 + i), 32'h200 + 32'(i), 1'b1, 6'(50 + i), 32'h500 + 32'(i));
            tick();
        end
        chk("pp.cheia", {31'd0, mem_pronto}, 32'd0);
        drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd60, 32'h600);
        tick();
        chk_porta("pp.pop", 1'b1, 6'd50, 32'h500);
        chk("pp.erro", {31'd0, erro_estouro}, 32'd0);
        chk("pp.ainda_cheia", {31'd0, mem_pronto}, 32'd0);
        idle();
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_porta($sformatf("pp.dren%0d", i), 1'b1, 6'(50 + i), 32'h500 + 32'(i));
        end
        tick();
        chk_porta("pp.novo", 1'b1, 6'd60, 32'h600);
        tick();
        chk("pp.fim.we", {31'd0, EscreveReg}, 32'd0);
        chk("pp.fim.pronto", {31'd0, mem_pronto}, 32'd1);

        $display("%0d/%0d checks passed", passados, total);
        $finish;
    end

endmodule
